// File: rtl/shared_mul_sched_pkg.sv
// -----------------------------------------------------------------------------
// shared_mul_sched_pkg
// Shared types and constants for the shared multiplier scheduler.
//   OP_W    : operand width of each requester (unsigned)
//   RES_W   : product / accumulator width
//   state_e : scheduler FSM state encoding
// -----------------------------------------------------------------------------
package shared_mul_sched_pkg;

    localparam int OP_W  = 8;
    localparam int RES_W = 2 * OP_W;

    // One partial-product state per quarter of the 8x8 product, then a
    // response-hold state.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PP0  = 3'd1,
        PP1  = 3'd2,
        PP2  = 3'd3,
        PP3  = 3'd4,
        RESP = 3'd5
    } state_e;

endpackage

// File: rtl/shared_mul_sched_mul4x4.sv
// -----------------------------------------------------------------------------
// mul4x4_core
// Purely combinational 4x4 unsigned multiplier; the single shared arithmetic
// resource of the scheduler.
// Ports:
//   a [3:0] : multiplicand nibble
//   b [3:0] : multiplier nibble
//   p [7:0] : unsigned product a*b
// -----------------------------------------------------------------------------
module mul4x4_core
    import shared_mul_sched_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    // Widen before multiplying so the product is computed at full width.
    assign p = {4'b0000, a} * {4'b0000, b};

endmodule

// File: rtl/shared_mul_sched.sv
// -----------------------------------------------------------------------------
// shared_mul_sched
// Two requesters share one 4x4 multiplier to form 8x8 unsigned products.
// A request is accepted in IDLE, the product is built from four nibble
// partial products over PP0..PP3, and held in RESP until consumed.
// Parameters:
//   FAIR : 1 = round-robin between requesters, 0 = requester 0 wins ties
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid[1:0]      : per-requester request
//   req_ready[1:0]      : per-requester accept (one-hot, IDLE only)
//   req_a0/b0, a1/b1    : requester 0 / 1 operands
//   rsp_valid/ready     : response handshake
//   rsp_data[15:0]      : product
//   rsp_id              : requester that owns rsp_data
//   busy                : high whenever not IDLE
//   done_cnt[15:0]      : wrapping count of consumed responses
// -----------------------------------------------------------------------------
module shared_mul_sched
    import shared_mul_sched_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OP_W-1:0]  req_a0,
    input  logic [OP_W-1:0]  req_b0,
    input  logic [OP_W-1:0]  req_a1,
    input  logic [OP_W-1:0]  req_b1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_data,
    output logic             rsp_id,
    output logic             busy,
    output logic [15:0]      done_cnt
);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   a_q, a_d;
    logic [OP_W-1:0]   b_q, b_d;
    logic [RES_W-1:0]  acc_q, acc_d;
    logic              id_q, id_d;
    logic              last_q, last_d;     // requester granted most recently
    logic [15:0]       done_cnt_q, done_cnt_d;

    logic [1:0]        grant;
    logic [3:0]        mul_a, mul_b;
    logic [7:0]        mul_p;

    mul4x4_core u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // -------------------------------------------------------------------------
    // Arbiter: a lone request is always granted; on a tie the round-robin
    // variant picks the requester that did not win last time.
    // -------------------------------------------------------------------------
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (FAIR && !last_q) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state, datapath and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        id_d      = id_q;
        last_d    = last_q;
        req_ready = 2'b00;
        mul_a     = a_q[3:0];
        mul_b     = b_q[3:0];

        case (state_q)
            IDLE: begin
                // Reset wins over a same-cycle handshake, so no accept is shown.
                req_ready = rst ? 2'b00 : grant;
                if (grant != 2'b00) begin
                    state_d = PP0;
                    id_d    = grant[1];
                    last_d  = grant[1];
                    a_d     = grant[1] ? req_a1 : req_a0;
                    b_d     = grant[1] ? req_b1 : req_b0;
                end
            end
            PP0: begin
                mul_a   = a_q[3:0];
                mul_b   = b_q[3:0];
                acc_d   = {8'h00, mul_p};
                state_d = PP1;
            end
            PP1: begin
                mul_a   = a_q[7:4];
                mul_b   = b_q[3:0];
                acc_d   = acc_q + {4'h0, mul_p, 4'h0};
                state_d = PP2;
            end
            PP2: begin
                mul_a   = a_q[3:0];
                mul_b   = b_q[7:4];
                acc_d   = acc_q + {4'h0, mul_p, 4'h0};
                state_d = PP3;
            end
            PP3: begin
                mul_a   = a_q[7:4];
                mul_b   = b_q[7:4];
                acc_d   = acc_q + {mul_p, 8'h00};
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done_cnt_d = (rsp_valid && rsp_ready) ? done_cnt_q + 16'd1 : done_cnt_q;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every register sample the values
        // from before this edge, independent of statement order.
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            id_q       <= 1'b0;
            last_q     <= 1'b1;    // first tie after reset goes to requester 0
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            id_q       <= id_d;
            last_q     <= last_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    // Response fields are forced to zero outside RESP.
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_valid ? acc_q : '0;
    assign rsp_id    = rsp_valid & id_q;
    assign busy      = (state_q != IDLE);
    assign done_cnt  = done_cnt_q;

endmodule
